// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock-enable divider.
// Each channel counts 0..activeP and emits a one-cycle slowEnPulse on the
// terminal count, so the pulse period is activeP+1 cycles. A per-channel copy
// of the pulse comes out DELAY cycles later on slowEnPulse_d.
// New prescale values are written through a valid/ready port into a shadow
// register. The shadow value moves into the active register only at a period
// boundary, or when the channel is disabled, so no period is ever cut short
// or stretched.
//
// Ports
//   clk_i            rising-edge clock
//   resetN_i         synchronous active-low reset
//   chEn_i           per-channel run enable
//   oneShot_i        per-channel mode: 1 = single pulse then park, 0 = periodic
//   cfgValid_i       configuration write request
//   cfgChan_i        target channel of the write
//   cfgValue_i       new prescale value
//   cfgReady_o       write is taken when cfgValid_i && cfgReady_o at an edge
//   slowEnPulse_o    one-cycle enable pulse per channel
//   slowEnPulse_d_o  slowEnPulse_o delayed by DELAY cycles
//   done_o           one-shot channel has fired and is parked
module clk_div_multi #(
   parameter int WIDTH         = 5,
   parameter int CHANNELS      = 4,
   parameter int DELAY         = 1,
   parameter int INIT_PRESCALE = 4,
   localparam int CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk_i,
   input  logic                resetN_i,
   input  logic [CHANNELS-1:0] chEn_i,
   input  logic [CHANNELS-1:0] oneShot_i,
   input  logic                cfgValid_i,
   input  logic [CW-1:0]       cfgChan_i,
   input  logic [WIDTH-1:0]    cfgValue_i,
   output logic                cfgReady_o,
   output logic [CHANNELS-1:0] slowEnPulse_o,
   output logic [CHANNELS-1:0] slowEnPulse_d_o,
   output logic [CHANNELS-1:0] done_o
);

   logic [WIDTH-1:0]    cnt_q    [CHANNELS];
   logic [WIDTH-1:0]    cnt_d    [CHANNELS];
   logic [WIDTH-1:0]    active_q [CHANNELS];
   logic [WIDTH-1:0]    active_d [CHANNELS];
   logic [WIDTH-1:0]    shadow_q [CHANNELS];
   logic [WIDTH-1:0]    shadow_d [CHANNELS];
   logic [CHANNELS-1:0] pending_q, pending_d;
   logic [CHANNELS-1:0] pulse_q, pulse_d;
   logic [CHANNELS-1:0] done_q, done_d;
   logic [CHANNELS-1:0] pipe_q   [DELAY];

   logic                cfg_ready;
   logic [CHANNELS-1:0] cfg_wr;

   // Out-of-range channel numbers match no channel, so they stay ready and
   // the write is silently dropped.
   always_comb begin
      cfg_ready = 1'b1;
      cfg_wr    = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (cfgChan_i == CW'(c)) begin
            cfg_ready = !pending_q[c];
         end
      end
      for (int c = 0; c < CHANNELS; c++) begin
         cfg_wr[c] = cfgValid_i && cfg_ready && (cfgChan_i == CW'(c));
      end
   end

   always_comb begin
      pulse_d   = '0;
      done_d    = done_q;
      pending_d = pending_q;
      for (int c = 0; c < CHANNELS; c++) begin
         cnt_d[c]    = cnt_q[c];
         active_d[c] = active_q[c];
         shadow_d[c] = shadow_q[c];

         if (!chEn_i[c]) begin
            cnt_d[c]  = '0;
            done_d[c] = 1'b0;
            if (pending_q[c]) begin
               active_d[c]  = shadow_q[c];
               pending_d[c] = 1'b0;
            end
         end else if (done_q[c]) begin
            cnt_d[c] = '0;
         end else if (cnt_q[c] == active_q[c]) begin
            cnt_d[c]   = '0;
            pulse_d[c] = 1'b1;
            if (oneShot_i[c]) begin
               done_d[c] = 1'b1;
            end
            // Swap only on the terminal edge so the next period starts clean.
            if (pending_q[c]) begin
               active_d[c]  = shadow_q[c];
               pending_d[c] = 1'b0;
            end
         end else begin
            cnt_d[c] = cnt_q[c] + 1'b1;
         end

         // A write can only land when pending_q is clear, so it never
         // collides with a swap in the same cycle.
         if (cfg_wr[c]) begin
            shadow_d[c]  = cfgValue_i;
            pending_d[c] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!resetN_i) begin
         for (int c = 0; c < CHANNELS; c++) begin
            cnt_q[c]    <= '0;
            active_q[c] <= WIDTH'(INIT_PRESCALE);
            shadow_q[c] <= WIDTH'(INIT_PRESCALE);
         end
         pending_q <= '0;
         pulse_q   <= '0;
         done_q    <= '0;
         for (int k = 0; k < DELAY; k++) begin
            pipe_q[k] <= '0;
         end
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            cnt_q[c]    <= cnt_d[c];
            active_q[c] <= active_d[c];
            shadow_q[c] <= shadow_d[c];
         end
         pending_q <= pending_d;
         pulse_q   <= pulse_d;
         done_q    <= done_d;
         // Free-running shift so a pulse already in flight still emerges
         // after its channel is disabled.
         pipe_q[0] <= pulse_q;
         for (int k = 1; k < DELAY; k++) begin
            pipe_q[k] <= pipe_q[k-1];
         end
      end
   end

   assign cfgReady_o      = cfg_ready;
   assign slowEnPulse_o   = pulse_q;
   assign slowEnPulse_d_o = pipe_q[DELAY-1];
   assign done_o          = done_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Testbench for clk_div_multi: four channels, DELAY=3, INIT_PRESCALE=4.
// Expected outputs for every edge are pushed into a scoreboard queue before
// the edge and popped and compared just after it.
module tb_clk_div_multi;

   localparam int WIDTH    = 5;
   localparam int CHANNELS = 4;
   localparam int DELAY    = 3;
   localparam int INIT_P   = 4;

   logic             clk = 1'b0;
   logic             resetN;
   logic [3:0]       chEn;
   logic [3:0]       oneShot;
   logic             cfgValid;
   logic [1:0]       cfgChan;
   logic [WIDTH-1:0] cfgValue;
   logic             cfgReady;
   logic [3:0]       slowEnPulse;
   logic [3:0]       slowEnPulse_d;
   logic [3:0]       done;

   clk_div_multi #(
      .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DELAY(DELAY), .INIT_PRESCALE(INIT_P)
   ) dut (
      .clk_i(clk), .resetN_i(resetN), .chEn_i(chEn), .oneShot_i(oneShot),
      .cfgValid_i(cfgValid), .cfgChan_i(cfgChan), .cfgValue_i(cfgValue),
      .cfgReady_o(cfgReady), .slowEnPulse_o(slowEnPulse),
      .slowEnPulse_d_o(slowEnPulse_d), .done_o(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] p;
      logic [3:0] d;
      logic [3:0] dn;
   } exp_t;

   exp_t       sb_q[$];
   logic [3:0] hist [DELAY];
   int         n_cmp = 0;
   int         n_err = 0;
   string      phase = "reset";

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s/%s: got %0d expected %0d at %0t", phase, tag, obs, exp, $time);
      end
   endtask

   // One clock edge with expected pulse and done vectors; the delayed pulse
   // expectation comes from the bench's own history of expected pulses.
   task automatic step(input logic [3:0] ep, input logic [3:0] edn, input bit rst);
      exp_t e;
      e.p  = ep;
      e.dn = edn;
      if (rst) begin
         e.d = '0;
         for (int k = 0; k < DELAY; k++) hist[k] = '0;
      end else begin
         e.d = hist[DELAY-1];
         for (int k = DELAY-1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = ep;
      end
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk("pulse", slowEnPulse, e.p);
      chk("pulse_d", slowEnPulse_d, e.d);
      chk("done", done, e.dn);
   endtask

   int         per [4] = '{1, 4, 8, 32};
   logic [3:0] ep;

   initial begin
      resetN   = 1'b0;
      chEn     = '0;
      oneShot  = '0;
      cfgValid = 1'b0;
      cfgChan  = '0;
      cfgValue = '0;
      for (int k = 0; k < DELAY; k++) hist[k] = '0;

      step(4'h0, 4'h0, 1'b1);
      step(4'h0, 4'h0, 1'b1);
      chk("rdy_reset", cfgReady, 1);

      // Channel 0 periodic at the reset prescale of 4.
      phase  = "p4";
      resetN = 1'b1;
      chEn   = 4'b0001;
      for (int i = 1; i <= 99; i++) step({3'b0, (i % 5 == 0)}, 4'h0, 1'b0);

      // Reprogram channel 0 to 7 while disabled.
      phase    = "cfg7";
      chEn     = '0;
      cfgValid = 1'b1;
      cfgChan  = 2'd0;
      cfgValue = 5'd7;
      step(4'h0, 4'h0, 1'b0);
      chk("rdy_pend", cfgReady, 0);
      cfgValid = 1'b0;
      step(4'h0, 4'h0, 1'b0);
      chk("rdy_swap", cfgReady, 1);

      phase = "p7";
      chEn  = 4'b0001;
      for (int i = 1; i <= 99; i++) step({3'b0, (i % 8 == 0)}, 4'h0, 1'b0);

      // All four channels with prescales 0/3/7/31.
      phase    = "cfg4";
      chEn     = '0;
      cfgValid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cfgChan  = 2'(c);
         cfgValue = 5'(per[c] - 1);
         step(4'h0, 4'h0, 1'b0);
      end
      cfgValid = 1'b0;
      step(4'h0, 4'h0, 1'b0);

      phase = "multi";
      chEn  = 4'hF;
      for (int i = 1; i <= 70; i++) begin
         for (int c = 0; c < 4; c++) ep[c] = (i % per[c] == 0);
         step(ep, 4'h0, 1'b0);
      end

      // Channel 1 at 3, write 6 mid-period, second write held off.
      phase   = "midwr";
      chEn    = '0;
      step(4'h0, 4'h0, 1'b0);
      chEn    = 4'b0010;
      cfgChan = 2'd1;
      for (int i = 1; i <= 30; i++) begin
         cfgValid = (i == 3) || (i == 4);
         cfgValue = (i == 3) ? 5'd6 : 5'd2;
         step({2'b0, (i == 4) || (i > 4 && (i - 4) % 7 == 0), 1'b0}, 4'h0, 1'b0);
         if (i == 3) chk("rdy_wait", cfgReady, 0);
         if (i == 4) chk("rdy_free", cfgReady, 1);
      end
      cfgValid = 1'b0;

      // One-shot on channel 2 with prescale 5.
      phase    = "oneshot";
      chEn     = '0;
      cfgValid = 1'b1;
      cfgChan  = 2'd2;
      cfgValue = 5'd5;
      step(4'h0, 4'h0, 1'b0);
      cfgValid = 1'b0;
      step(4'h0, 4'h0, 1'b0);
      oneShot  = 4'b0100;
      chEn     = 4'b0100;
      for (int i = 1; i <= 56; i++)
         step({1'b0, (i == 6), 2'b0}, {1'b0, (i >= 6), 2'b0}, 1'b0);
      chEn = '0;
      step(4'h0, 4'h0, 1'b0);
      chEn = 4'b0100;
      for (int i = 1; i <= 8; i++)
         step({1'b0, (i == 6), 2'b0}, {1'b0, (i >= 6), 2'b0}, 1'b0);

      // Delayed pulse survives a disable right after the pulse.
      phase   = "dly";
      oneShot = '0;
      chEn    = '0;
      step(4'h0, 4'h0, 1'b0);
      chEn = 4'b0010;
      for (int i = 1; i <= 7; i++) step({2'b0, (i == 7), 1'b0}, 4'h0, 1'b0);
      chEn = '0;
      for (int i = 1; i <= 5; i++) step(4'h0, 4'h0, 1'b0);

      // Write on the terminal edge stays pending; reset then flushes it
      // along with the pulse still in the delay pipe.
      phase   = "rstfly";
      chEn    = 4'b0010;
      cfgChan = 2'd1;
      for (int i = 1; i <= 7; i++) begin
         cfgValid = (i == 7);
         cfgValue = 5'd2;
         step({2'b0, (i == 7), 1'b0}, 4'h0, 1'b0);
      end
      chk("rdy_term", cfgReady, 0);
      cfgValid = 1'b0;
      resetN   = 1'b0;
      step(4'h0, 4'h0, 1'b1);
      chk("rdy_rst", cfgReady, 1);
      resetN = 1'b1;

      // Reset mid-count restarts from zero at the reset prescale.
      phase = "rstcnt";
      chEn  = 4'b0011;
      step(4'h0, 4'h0, 1'b0);
      step(4'h0, 4'h0, 1'b0);
      resetN = 1'b0;
      step(4'h0, 4'h0, 1'b1);
      resetN = 1'b1;
      for (int i = 1; i <= 15; i++)
         step({2'b0, (i % 5 == 0), (i % 5 == 0)}, 4'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
